// File: rtl/emu_ff_scan_ctrl_if.sv
// Bundle of host command, dump/restore beat streams and DUT scan pins for emu_ff_scan_ctrl.
// slave is the controller's view; master is the host/DUT-side view.
interface emu_ff_scan_ctrl_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic                  cmd_keep;
    logic                  done;
    logic                  busy;
    logic                  emu_halt;
    logic                  ff_scan;
    logic                  ff_dir;
    logic [DATA_WIDTH-1:0] ff_sdi;
    logic [DATA_WIDTH-1:0] ff_sdo;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [DATA_WIDTH-1:0] dout_data;
    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] din_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_keep, ff_sdo, dout_ready, din_valid, din_data,
        output cmd_ready, done, busy, emu_halt, ff_scan, ff_dir, ff_sdi,
               dout_valid, dout_data, din_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_keep, ff_sdo, dout_ready, din_valid, din_data,
        input  cmd_ready, done, busy, emu_halt, ff_scan, ff_dir, ff_sdi,
               dout_valid, dout_data, din_ready
    );
endinterface

// File: rtl/emu_ff_scan_ctrl.sv
// Host-side flip-flop scan chain controller: halts the emulated DUT, then dumps the chain
// (SDO looped back to SDI so state survives) or restores it from a beat source.
module emu_ff_scan_ctrl #(
    parameter int CHAIN_WORDS = 4,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    emu_ff_scan_ctrl_if.slave     bus,
    output logic [1:0]            dbg_state
);
    localparam int CNT_W = $clog2(CHAIN_WORDS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;

    localparam logic [1:0] OP_HALT   = 2'd2;
    localparam logic [1:0] OP_RESUME = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHAIN_WORDS - 1);

    logic [1:0]            state;
    logic                  halt_q;
    logic                  dir_q;
    logic                  keep_q;
    logic [CNT_W-1:0]      cnt;
    logic                  in_scan;
    logic                  shift;
    logic                  cmd_fire;
    logic [DATA_WIDTH-1:0] sdi_word;

    // Handshakes: a transfer happens on a cycle where valid & ready are both high.
    // Within SCAN the chain shifts exactly on the beat handshake, so a stalled
    // partner simply freezes the chain and no beat is dropped or repeated.
    assign in_scan  = (state == SCAN);
    assign shift    = in_scan & (dir_q ? bus.din_valid : bus.dout_ready);
    assign cmd_fire = bus.cmd_valid & (state == IDLE);
    assign sdi_word = (in_scan & dir_q) ? bus.din_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            halt_q <= 1'b0;
            dir_q  <= 1'b0;
            keep_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_HALT: begin
                                halt_q <= 1'b1;
                                state  <= FIN;
                            end
                            OP_RESUME: begin
                                halt_q <= 1'b0;
                                state  <= FIN;
                            end
                            default: begin
                                halt_q <= 1'b1;
                                dir_q  <= bus.cmd_op[0];
                                keep_q <= bus.cmd_keep;
                                cnt    <= '0;
                                state  <= SETTLE;
                            end
                        endcase
                    end
                end
                SETTLE: state <= SCAN;
                SCAN: begin
                    if (shift) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            halt_q <= keep_q;
                            state  <= FIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FIN);
    assign bus.emu_halt   = halt_q;
    assign bus.ff_dir     = (state != IDLE) ? dir_q : 1'b0;
    assign bus.ff_scan    = shift;
    assign bus.ff_sdi     = sdi_word;
    assign bus.dout_valid = in_scan & ~dir_q;
    assign bus.dout_data  = (in_scan & ~dir_q) ? bus.ff_sdo : '0;
    assign bus.din_ready  = in_scan & dir_q;
    assign dbg_state      = state;
endmodule

// File: doc/emu_ff_scan_ctrl.md
Name: emu_ff_scan_ctrl

Overview:
Host-side controller for the emulated DUT's flip-flop scan chain. It drives the halt/scan/dir/SDI pins and samples SDO.
- Dump: halts the DUT, streams the chain out as CHAIN_WORDS beats of DATA_WIDTH. The SDO-to-SDI loopback is preserved, so DUT state is unchanged after a full rotation.
- Restore: streams CHAIN_WORDS beats from a source into SDI.
- Sits between the checkpoint DMA/host mailbox and the DUT scan ports.

Parameters:
CHAIN_WORDS, 4, number of scan beats in the FF chain (must be >= 1)
DATA_WIDTH, 64, scan word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0=DUMP, 1=RESTORE, 2=HALT, 3=RESUME
cmd_keep  in  1  DUMP/RESTORE: keep halt asserted after completion
done  out  1  one-cycle completion pulse
busy  out  1  state != IDLE
emu_halt  out  1  DUT halt
ff_scan  out  1  chain shift enable
ff_dir  out  1  0 = loopback SDO->SDI (dump), 1 = SDI from ff_sdi (restore)
ff_sdi  out  DATA_WIDTH  restore word to chain
ff_sdo  in  DATA_WIDTH  chain output word
dout_valid  out  1  dump beat valid
dout_ready  in  1  dump sink ready
dout_data  out  DATA_WIDTH  dump beat
din_valid  in  1  restore beat valid
din_ready  out  1  restore source ready
din_data  in  DATA_WIDTH  restore beat

Behaviour:
- Reset values:
  - state=IDLE, halt_q=0, dir_q=0, keep_q=0, beat counter=0.
  - All outputs 0, except cmd_ready=1.
- Counter width is $clog2(CHAIN_WORDS+1).
- States: IDLE, SETTLE, SCAN, FIN.
- IDLE:
  - cmd_ready=1. Handshake is cmd_valid & cmd_ready. cmd_op, cmd_keep and the beat inputs are ignored otherwise.
  - DUMP/RESTORE accept: halt_q<=1, dir_q<=op[0], keep_q<=cmd_keep, cnt<=0, go to SETTLE.
  - HALT accept: halt_q<=1, go to FIN.
  - RESUME accept: halt_q<=0, go to FIN.
- SETTLE: one cycle with emu_halt=1 and ff_scan=0, then go to SCAN. The DUT is frozen before the first shift.
- SCAN, dump (dir_q=0):
  - dout_valid=1, dout_data=ff_sdo (combinational, no register stage).
  - ff_scan = dout_ready.
- SCAN, restore (dir_q=1):
  - din_ready=1, ff_sdi=din_data (combinational).
  - ff_scan = din_valid.
- Chain stall: whenever ff_scan=0 in SCAN, the chain holds. Backpressure never drops or duplicates a beat.
- Beat counting:
  - cnt increments on each ff_scan=1 cycle.
  - On the beat with cnt==CHAIN_WORDS-1: go to FIN and set halt_q<=keep_q.
- Outside SCAN: ff_scan=0, dout_valid=0, din_ready=0, ff_sdi=0.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- Pin drive:
  - emu_halt = halt_q in every state, so it is 1 through SETTLE and SCAN.
  - ff_dir = dir_q while busy, 0 in IDLE.
- Latency: a DUMP with a always-ready sink takes 1 (SETTLE) + CHAIN_WORDS (SCAN) + 1 (FIN) cycles after accept.
- emu_halt falls the cycle after the last beat when keep=0.
- HALT op when already halted: no-op, done still pulses. RESUME op when not halted: same.
- No new command is accepted until back in IDLE. A cmd_valid held during busy waits.
- Asynchronous reset mid-operation:
  - Immediate return to reset values; emu_halt drops.
  - The chain may be partially rotated or loaded, so the checkpoint is invalid. The host must reset the DUT or reissue RESTORE.

Test Plan:
- DUMP keep=0, dout_ready=1, CHAIN_WORDS=4 with the DUT loaded with known d1..d4 → 4 beats equal to the ff_sdo sequence; done at accept+6; emu_halt low after; DUT outputs unchanged.
- DUMP with dout_ready toggling 1,0,0,1,... → exactly 4 accepted beats, identical data to the stall-free run, ff_scan high only on handshake cycles, DUT state unchanged.
- RESTORE keep=1 of 4 words captured by a prior dump (din_valid gaps of 2 cycles) → DUT q outputs match the dumped round; emu_halt stays 1 after done; a following RESUME clears emu_halt with done one cycle after accept.
- HALT then DUMP keep=1 → emu_halt never drops across both commands; cmd_valid asserted during SCAN is not accepted until IDLE.
- rst_n pulsed low during beat 2 of a RESTORE → all outputs at reset values immediately; cmd_ready=1 after deassert; a new DUMP proceeds normally.
- Four dump/restore rounds with random d-data (0xdeadbeef-style patterns) → every restore reproduces its round's {q1,q2,q3,q4} exactly.
